vec_lane_sequencer: RTL and testbench

Sequences a vector arithmetic operation (addv/subv/mulv/xorv) lane by lane through one shared DATA_W-bit ALU, so vector instructions reuse the scalar ALU instead of needing LANES replicated ALUs. Sits in the execute stage between the decoded vector instruction (ALU control code plus two vector operands) and the ALU. It collects per-lane results into a result vector and reports completion and illegal-op errors. Pipeline control stalls issue on busy.

---
 rtl/vec_lane_sequencer.sv | 138 +++++++++++++
 tb/tb_vec_lane_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
// vec_lane_sequencer
// Runs a vector add/sub/mul/xor lane by lane through one shared scalar ALU
// and assembles the per-lane results into a result vector.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op_valid/op_ready request handshake; ready only while IDLE
//   op_ctrl           ALU code (000 add, 001 sub, 010 mul, 101 xor)
//   op_a, op_b        source vectors, lane i = bits [i*DATA_W +: DATA_W]
//   stall             freezes lane issue for the current cycle
//   alu_a/alu_b/alu_ctrl/alu_en  drive the shared ALU; alu_result returns
//   lane_idx          lane currently issued
//   busy              high in ISSUE or DONE
//   res_vec/res_zero  assembled result and its all-zero flag
//   res_valid         one-cycle completion pulse
//   op_err            one-cycle pulse when an illegal op is rejected
module vec_lane_sequencer #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2:0]              op_ctrl,
    input  logic [LANES*DATA_W-1:0] op_a,
    input  logic [LANES*DATA_W-1:0] op_b,
    input  logic                    stall,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [2:0]              alu_ctrl,
    output logic                    alu_en,
    input  logic [DATA_W-1:0]       alu_result,
    output logic [IDX_W-1:0]        lane_idx,
    output logic                    busy,
    output logic [LANES*DATA_W-1:0] res_vec,
    output logic                    res_valid,
    output logic                    res_zero,
    output logic                    op_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state_reg;
    logic [IDX_W-1:0]    lane_idx_reg;
    logic [2:0]          ctrl_reg;
    logic [DATA_W-1:0]   a_lane_reg   [LANES];
    logic [DATA_W-1:0]   b_lane_reg   [LANES];
    logic [DATA_W-1:0]   res_lane_reg [LANES];
    logic                res_valid_reg;
    logic                res_zero_reg;
    logic                op_err_reg;

    logic [DATA_W-1:0]   op_a_lane [LANES];
    logic [DATA_W-1:0]   op_b_lane [LANES];
    logic                ctrl_legal;
    logic                last_lane;

    // Unpack incoming operands and pack the result array onto the flat bus.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign op_a_lane[gi] = op_a[gi*DATA_W +: DATA_W];
        assign op_b_lane[gi] = op_b[gi*DATA_W +: DATA_W];
        assign res_vec[gi*DATA_W +: DATA_W] = res_lane_reg[gi];
    end

    assign ctrl_legal = (op_ctrl == 3'b000) || (op_ctrl == 3'b001) ||
                        (op_ctrl == 3'b010) || (op_ctrl == 3'b101);
    assign last_lane  = (lane_idx_reg == IDX_W'(LANES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            lane_idx_reg  <= '0;
            ctrl_reg      <= '0;
            res_valid_reg <= 1'b0;
            res_zero_reg  <= 1'b0;
            op_err_reg    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                res_lane_reg[i] <= '0;
            end
        end else begin
            res_valid_reg <= 1'b0;
            op_err_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        if (ctrl_legal) begin
                            ctrl_reg     <= op_ctrl;
                            lane_idx_reg <= '0;
                            state_reg    <= ISSUE;
                            for (int i = 0; i < LANES; i++) begin
                                a_lane_reg[i] <= op_a_lane[i];
                                b_lane_reg[i] <= op_b_lane[i];
                            end
                        end else begin
                            op_err_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        res_lane_reg[lane_idx_reg] <= alu_result;
                        // Lane 0 restarts the zero accumulation, so the previous
                        // flag survives until the new op's first lane lands.
                        res_zero_reg <= (alu_result == '0) &&
                                        ((lane_idx_reg == '0) || res_zero_reg);
                        if (last_lane) begin
                            lane_idx_reg  <= '0;
                            state_reg     <= DONE;
                            res_valid_reg <= 1'b1;
                        end else begin
                            lane_idx_reg <= lane_idx_reg + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign op_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign alu_en    = (state_reg == ISSUE);
    assign alu_a     = alu_en ? a_lane_reg[lane_idx_reg] : '0;
    assign alu_b     = alu_en ? b_lane_reg[lane_idx_reg] : '0;
    assign alu_ctrl  = alu_en ? ctrl_reg : 3'b000;
    assign lane_idx  = lane_idx_reg;
    assign res_valid = res_valid_reg;
    assign res_zero  = res_zero_reg;
    assign op_err    = op_err_reg;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Testbench for vec_lane_sequencer: directed and randomized vector ops
// checked against a lane-wise arithmetic reference model.
module tb_vec_lane_sequencer;

    localparam int L = 16;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [2:0]     op_ctrl;
    logic [L*W-1:0] op_a;
    logic [L*W-1:0] op_b;
    logic           stall;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_ctrl;
    logic           alu_en;
    logic [W-1:0]   alu_result;
    logic [3:0]     lane_idx;
    logic           busy;
    logic [L*W-1:0] res_vec;
    logic           res_valid;
    logic           res_zero;
    logic           op_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc;

    vec_lane_sequencer #(.LANES(L), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_ctrl(op_ctrl), .op_a(op_a), .op_b(op_b), .stall(stall),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
        .alu_result(alu_result), .lane_idx(lane_idx), .busy(busy),
        .res_vec(res_vec), .res_valid(res_valid), .res_zero(res_zero),
        .op_err(op_err)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a * alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    function automatic logic [L*W-1:0] model(input logic [2:0] c,
                                             input logic [L*W-1:0] a,
                                             input logic [L*W-1:0] b);
        logic [L*W-1:0] r;
        logic [W-1:0] x, y, z;
        r = '0;
        for (int i = 0; i < L; i++) begin
            x = a[i*W +: W];
            y = b[i*W +: W];
            case (c)
                3'b000:  z = x + y;
                3'b001:  z = x - y;
                3'b010:  z = x * y;
                default: z = x ^ y;
            endcase
            r[i*W +: W] = z;
        end
        return r;
    endfunction

    function automatic logic [L*W-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [L*W-1:0] obs,
                         input logic [L*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issue one op and follow it to its res_valid cycle. Stalls are inserted
    // when lane sl0/sl1 is on the ALU; operands are scrambled during the op.
    task automatic do_op(input string name, input logic [2:0] c,
                         input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                         input int sl0, input int sn0, input int sl1, input int sn1,
                         input bit hold);
        logic [L*W-1:0] exp;
        int edges, en_cnt, left0, left1, nstall;
        bit got, stalled;
        logic [3:0] p_idx;
        logic [W-1:0] p_a, p_b;
        exp = model(c, a, b);
        left0 = sn0; left1 = sn1; nstall = sn0 + sn1;
        edges = 0; en_cnt = 0; got = 0;
        op_ctrl = c; op_a = a; op_b = b; op_valid = 1'b1;
        check({name, "_ready"}, op_ready, 1);
        step();
        if (!hold) op_valid = 1'b0;
        check({name, "_busy"}, busy, 1);
        while (!got && edges < 100) begin
            if (res_valid) begin
                got = 1;
            end else begin
                if (alu_en) en_cnt++;
                op_a = rand_vec(); op_b = rand_vec();
                op_ctrl = 3'($urandom_range(0, 7));
                stalled = 0;
                if (alu_en && int'(lane_idx) == sl0 && left0 > 0) begin
                    stall = 1'b1; left0--; stalled = 1;
                end else if (alu_en && int'(lane_idx) == sl1 && left1 > 0) begin
                    stall = 1'b1; left1--; stalled = 1;
                end else begin
                    stall = 1'b0;
                end
                p_idx = lane_idx; p_a = alu_a; p_b = alu_b;
                step();
                edges++;
                if (stalled) begin
                    check({name, "_stall_idx"}, lane_idx, p_idx);
                    check({name, "_stall_a"}, alu_a, p_a);
                    check({name, "_stall_b"}, alu_b, p_b);
                    check({name, "_stall_en"}, alu_en, 1);
                end
            end
        end
        stall = 1'b0;
        check({name, "_got_valid"}, got, 1);
        check({name, "_latency"}, edges, L + nstall);
        check({name, "_en_cycles"}, en_cnt, L + nstall);
        check({name, "_res_vec"}, res_vec, exp);
        check({name, "_res_zero"}, res_zero, (exp == '0));
        check({name, "_done_en"}, alu_en, 0);
        check({name, "_done_ready"}, op_ready, 0);
        check({name, "_no_err"}, op_err, 0);
        done_cyc = cyc;
        $display("op %s ctrl=%0b stalls=%0d latency=%0d res=%0h", name, c, nstall, edges, res_vec);
    endtask

    initial begin
        logic [L*W-1:0] va, vb, last_res;
        logic [2:0] illegal [4];
        logic [2:0] legal [4];
        int first_done, k;
        illegal = '{3'b011, 3'b111, 3'b100, 3'b110};
        legal   = '{3'b000, 3'b001, 3'b010, 3'b101};

        rst = 1'b1; op_valid = 1'b0; op_ctrl = '0; op_a = '0; op_b = '0; stall = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_ready", op_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_idx", lane_idx, 0);
        check("rst_res_vec", res_vec, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_zero", res_zero, 0);
        check("rst_op_err", op_err, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        $display("reset checked");

        // xorv: lane i = i ^ 0xFF
        for (int i = 0; i < L; i++) begin
            va[i*W +: W] = W'(i);
            vb[i*W +: W] = 8'hFF;
        end
        do_op("xorv", 3'b101, va, vb, -1, 0, -1, 0, 0);
        step();
        check("xorv_pulse_end", res_valid, 0);
        check("xorv_idle_ready", op_ready, 1);

        // subv with equal operands -> all zero, held afterwards
        va = rand_vec();
        do_op("subv_zero", 3'b001, va, va, -1, 0, -1, 0, 0);
        step(); step(); step();
        check("subv_hold_vec", res_vec, 0);
        check("subv_hold_zero", res_zero, 1);
        check("subv_hold_valid", res_valid, 0);

        // addv with wrap and stalls at lanes 5 and 15
        for (int i = 0; i < L; i++) begin
            va[i*W +: W] = 8'hFF;
            vb[i*W +: W] = 8'h02;
        end
        do_op("addv_stall", 3'b000, va, vb, 5, 3, 15, 1, 0);
        step();
        last_res = res_vec;

        // illegal controls are rejected with a single op_err pulse
        foreach (illegal[j]) begin
            op_ctrl = illegal[j]; op_a = rand_vec(); op_b = rand_vec(); op_valid = 1'b1;
            step();
            op_valid = 1'b0;
            check("ill_err", op_err, 1);
            check("ill_ready", op_ready, 1);
            check("ill_en", alu_en, 0);
            step();
            check("ill_err_end", op_err, 0);
            check("ill_busy", busy, 0);
            check("ill_en2", alu_en, 0);
            check("ill_res_kept", res_vec, last_res);
            $display("illegal ctrl=%0b rejected", illegal[j]);
        end

        // reset in the middle of an op
        op_ctrl = 3'b000; op_a = rand_vec(); op_b = rand_vec(); op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        k = 0;
        while (lane_idx != 4'd7 && k < 40) begin
            step(); k++;
        end
        check("mid_idx7", lane_idx, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", op_ready, 1);
        check("mid_rst_vec", res_vec, 0);
        check("mid_rst_en", alu_en, 0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_valid", res_valid, 0);
            step();
        end
        $display("mid-op reset checked");
        for (int i = 0; i < L; i++) begin
            va[i*W +: W] = 8'd3;
            vb[i*W +: W] = 8'd5;
        end
        do_op("mulv", 3'b010, va, vb, -1, 0, -1, 0, 0);
        step();

        // back-to-back with op_valid held high throughout
        va = rand_vec(); vb = rand_vec();
        do_op("b2b_first", 3'b000, va, vb, -1, 0, -1, 0, 1);
        first_done = done_cyc;
        op_ctrl = 3'b101; op_a = rand_vec(); op_b = rand_vec();
        step();
        check("b2b_idle_ready", op_ready, 1);
        check("b2b_idle_valid", res_valid, 0);
        va = rand_vec(); vb = rand_vec();
        do_op("b2b_second", 3'b001, va, vb, -1, 0, -1, 0, 0);
        check("b2b_gap", done_cyc - first_done, L + 2);
        step();

        // randomized ops
        for (int r = 0; r < 6; r++) begin
            va = rand_vec(); vb = rand_vec();
            do_op("rand", legal[$urandom_range(0, 3)], va, vb,
                  int'($urandom_range(0, L - 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, L - 1)), int'($urandom_range(0, 2)), 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
